// File: rtl/sign_ext_pkg.sv
// ==========================================================================
// sign_ext_pkg : lane widths and vector types shared by the sign extender
// Rev 1.0
// ==========================================================================
`default_nettype none

package sign_ext_pkg;

  localparam int A_IN_W  = 8;
  localparam int A_OUT_W = 16;
  localparam int B_IN_W  = 16;
  localparam int B_OUT_W = 32;

  typedef logic [A_IN_W-1:0]  a_in_t;
  typedef logic [A_OUT_W-1:0] a_out_t;
  typedef logic [B_IN_W-1:0]  b_in_t;
  typedef logic [B_OUT_W-1:0] b_out_t;

endpackage

`default_nettype wire

// File: rtl/sign_ext_top_if.sv
// ==========================================================================
// sign_ext_top_if : operand/result bundle for both lanes (zext optional)
// Rev 1.0
// ==========================================================================
`default_nettype none

interface sign_ext_top_if;
  import sign_ext_pkg::*;

  a_in_t  in_8;
  b_in_t  in_16;
  a_out_t out_8_16;
  b_out_t out_16_32;
`ifdef SIGN_EXT_TOP_ZERO_EXT_EN
  logic   zext;
`endif

  modport master (
    output in_8,
    output in_16,
`ifdef SIGN_EXT_TOP_ZERO_EXT_EN
    output zext,
`endif
    input  out_8_16,
    input  out_16_32
  );

  modport slave (
    input  in_8,
    input  in_16,
`ifdef SIGN_EXT_TOP_ZERO_EXT_EN
    input  zext,
`endif
    output out_8_16,
    output out_16_32
  );

endinterface

`default_nettype wire

// File: rtl/sign_ext.sv
// ==========================================================================
// sign_ext : combinational IN_W -> OUT_W widening (zext when enabled)
// Rev 1.0
// ==========================================================================
`default_nettype none

module sign_ext #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
`ifdef SIGN_EXT_TOP_ZERO_EXT_EN
  input  logic             zext,
`endif
  output logic [OUT_W-1:0] dout
);

  logic fill;

`ifdef SIGN_EXT_TOP_ZERO_EXT_EN
  assign fill = din[IN_W-1] & ~zext;
`else
  assign fill = din[IN_W-1];
`endif

  generate
    if (OUT_W > IN_W) begin : g_widen
      assign dout = {{(OUT_W-IN_W){fill}}, din};
    end else begin : g_bad_width
      // A non-widening instance is a configuration error, not a silent truncation.
      $error("sign_ext: OUT_W must exceed IN_W");
      assign dout = '0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/sign_ext_top.sv
// ==========================================================================
// sign_ext_top : dual-lane registered sign extender (8->16, 16->32)
// Optional zero-extend select via macro SIGN_EXT_TOP_ZERO_EXT_EN. Rev 1.0
// ==========================================================================
`default_nettype none

module sign_ext_top
  import sign_ext_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  sign_ext_top_if.slave bus
);

  a_out_t ext_a;
  b_out_t ext_b;
  a_out_t out_a_q;
  b_out_t out_b_q;

  sign_ext #(.IN_W(A_IN_W), .OUT_W(A_OUT_W)) u_lane_a (
    .din  (bus.in_8),
`ifdef SIGN_EXT_TOP_ZERO_EXT_EN
    .zext (bus.zext),
`endif
    .dout (ext_a)
  );

  sign_ext #(.IN_W(B_IN_W), .OUT_W(B_OUT_W)) u_lane_b (
    .din  (bus.in_16),
`ifdef SIGN_EXT_TOP_ZERO_EXT_EN
    .zext (bus.zext),
`endif
    .dout (ext_b)
  );

  // Reset wins over sampling, so the operand present at a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      out_a_q <= ext_a;
      out_b_q <= ext_b;
    end
  end

  assign bus.out_8_16  = out_a_q;
  assign bus.out_16_32 = out_b_q;

endmodule

`default_nettype wire

// File: tb/tb_sign_ext_top.sv
// ==========================================================================
// tb_sign_ext_top : table-driven check of sign_ext_top plus corner sequences
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_sign_ext_top;
  import sign_ext_pkg::*;

  typedef struct {
    logic   rst;
    a_in_t  a;
    b_in_t  b;
    a_out_t exp_a;
    b_out_t exp_b;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sign_ext_top_if bus ();

  sign_ext_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    total = 0;
    bad   = 0;
    rst        = 1'b1;
    bus.in_8   = 8'hFF;
    bus.in_16  = 16'hFFFF;
`ifdef SIGN_EXT_TOP_ZERO_EXT_EN
    bus.zext   = 1'b0;
`endif

    vecs.push_back('{1'b1, 8'hFF, 16'hFFFF, 16'h0000, 32'h00000000});
    vecs.push_back('{1'b1, 8'hFF, 16'hFFFF, 16'h0000, 32'h00000000});
    vecs.push_back('{1'b0, 8'h00, 16'h0000, 16'h0000, 32'h00000000});
    vecs.push_back('{1'b0, 8'h01, 16'h0001, 16'h0001, 32'h00000001});
    vecs.push_back('{1'b0, 8'h81, 16'h7007, 16'hFF81, 32'h00007007});
    vecs.push_back('{1'b0, 8'hFF, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF});
    vecs.push_back('{1'b0, 8'hC3, 16'hC00C, 16'hFFC3, 32'hFFFFC00C});
    vecs.push_back('{1'b0, 8'h42, 16'h4004, 16'h0042, 32'h00004004});
    vecs.push_back('{1'b0, 8'h7F, 16'h8000, 16'h007F, 32'hFFFF8000});
    vecs.push_back('{1'b0, 8'h80, 16'h7FFF, 16'hFF80, 32'h00007FFF});
    vecs.push_back('{1'b1, 8'h55, 16'hAAAA, 16'h0000, 32'h00000000});
    vecs.push_back('{1'b0, 8'hA5, 16'h5A5A, 16'hFFA5, 32'h00005A5A});
    vecs.push_back('{1'b0, 8'h5A, 16'hA5A5, 16'h005A, 32'hFFFFA5A5});

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      bus.in_8  = vecs[i].a;
      bus.in_16 = vecs[i].b;
      tick();
      check($sformatf("vec%0d_out_8_16", i),  {16'h0, bus.out_8_16}, {16'h0, vecs[i].exp_a});
      check($sformatf("vec%0d_out_16_32", i), bus.out_16_32,         vecs[i].exp_b);
    end

    // Input change between edges must not reach the registered outputs.
    bus.in_8  = 8'h80;
    bus.in_16 = 16'h8000;
    #3;
    check("no_comb_path_a", {16'h0, bus.out_8_16}, 32'h0000005A);
    check("no_comb_path_b", bus.out_16_32,         32'hFFFFA5A5);
    tick();
    check("after_edge_a", {16'h0, bus.out_8_16}, 32'h0000FF80);
    check("after_edge_b", bus.out_16_32,         32'hFFFF8000);

    // Change only lane B; lane A result must hold.
    bus.in_16 = 16'h0001;
    tick();
    check("lane_indep_a", {16'h0, bus.out_8_16}, 32'h0000FF80);
    check("lane_indep_b", bus.out_16_32,         32'h00000001);

`ifdef SIGN_EXT_TOP_ZERO_EXT_EN
    bus.in_8  = 8'h81;
    bus.in_16 = 16'hC00C;
    bus.zext  = 1'b1;
    tick();
    check("zext1_a", {16'h0, bus.out_8_16}, 32'h00000081);
    check("zext1_b", bus.out_16_32,         32'h0000C00C);
    bus.zext  = 1'b0;
    tick();
    check("zext0_a", {16'h0, bus.out_8_16}, 32'h0000FF81);
    check("zext0_b", bus.out_16_32,         32'hFFFFC00C);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
